// File: rtl/des_sau_pkg.sv
// rtl/des_sau_pkg.sv - shared types and constants for the DES serial adapter sequencer
package des_sau_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [7:0] SAU_IDLE_BYTE   = 8'hFF;
   localparam int         BLOCK_W         = 64;
   localparam int         RX_SKIP_DEF     = 2;
   localparam int         TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/sau_block_pack.sv
// rtl/sau_block_pack.sv - byte-wide load/shift register with saturating byte index
// Shifts left, inserting din at the LSB end; q exposes the top OUT_W bits. BYTES must be >= 2.
module sau_block_pack
   import des_sau_pkg::*;
#(
   parameter int BYTES = 8,
   parameter int OUT_W = 8*BYTES,
   parameter int IW    = $clog2(BYTES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               shift,
   input  logic [8*BYTES-1:0] load_data,
   input  logic [7:0]         din,
   output logic [OUT_W-1:0]   q,
   output logic               full
);

   logic [8*BYTES-1:0] data;
   logic [IW-1:0]      idx;

   assign full = (idx == IW'(BYTES));
   assign q    = data[8*BYTES-1 -: OUT_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         idx  <= '0;
      end else if (load) begin
         data <= load_data;
         idx  <= '0;
      end else if (shift && !full) begin
         data <= {data[8*BYTES-9:0], din};
         idx  <= idx + 1'b1;
      end
   end

endmodule

// File: rtl/sau_block_ctrl.sv
// rtl/sau_block_ctrl.sv - sequences one serial adapter unit for 64-bit DES blocks
// Optional watchdog enabled by defining SAU_CTRL_TIMEOUT_EN.
module sau_block_ctrl
   import des_sau_pkg::*;
#(
   parameter int BLOCK_BYTES = 8,
   parameter int RX_SKIP     = RX_SKIP_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [8*BLOCK_BYTES-1:0] tx_block,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic [8*BLOCK_BYTES-1:0] rx_block,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic                     sau_en,
   output logic [7:0]               sau_din,
   input  logic                     sau_infl,
   input  logic [7:0]               sau_dout,
   input  logic                     sau_outfl,
   output logic                     busy,
   output logic                     err
);

   localparam int W  = 8*BLOCK_BYTES;
   localparam int SW = $clog2(RX_SKIP + 2);

   state_t        state;
   logic          sau_en_q;
   logic [7:0]    tx_head;
   logic          tx_done;
   logic          rx_done;
   logic [SW-1:0] skip_cnt;
   logic          accept;
   logic          infl_ev;
   logic          outfl_ev;
   logic          skipping;

   assign accept   = (state == IDLE) && tx_valid && tx_ready;
   assign infl_ev  = (state == RUN) && sau_infl;
   assign outfl_ev = (state == RUN) && sau_outfl;
   assign skipping = (skip_cnt < SW'(RX_SKIP));

   sau_block_pack #(.BYTES(BLOCK_BYTES), .OUT_W(8)) u_tx_unpack (
      .clk       (clk),
      .rst_n     (en),
      .load      (accept),
      .shift     (infl_ev),
      .load_data (tx_block),
      .din       (SAU_IDLE_BYTE),
      .q         (tx_head),
      .full      (tx_done)
   );

   // Link-fill bytes right after enable never reach the pack register.
   sau_block_pack #(.BYTES(BLOCK_BYTES), .OUT_W(W)) u_rx_pack (
      .clk       (clk),
      .rst_n     (en),
      .load      (accept),
      .shift     (outfl_ev && !skipping),
      .load_data ('0),
      .din       (sau_dout),
      .q         (rx_block),
      .full      (rx_done)
   );

   assign sau_din = (state == RUN) ? tx_head : SAU_IDLE_BYTE;
   assign sau_en  = sau_en_q & en;
   assign busy    = (state != IDLE);

`ifdef SAU_CTRL_TIMEOUT_EN
   logic [9:0] wd;
   logic       err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         state    <= IDLE;
         sau_en_q <= 1'b0;
         tx_ready <= 1'b0;
         rx_valid <= 1'b0;
         skip_cnt <= '0;
`ifdef SAU_CTRL_TIMEOUT_EN
         wd       <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx_ready <= 1'b1;
               if (accept) begin
                  state    <= RUN;
                  sau_en_q <= 1'b1;
                  tx_ready <= 1'b0;
                  skip_cnt <= '0;
`ifdef SAU_CTRL_TIMEOUT_EN
                  wd       <= '0;
`endif
               end
            end
            RUN: begin
               if (outfl_ev && skipping)
                  skip_cnt <= skip_cnt + 1'b1;
`ifdef SAU_CTRL_TIMEOUT_EN
               wd <= (sau_infl || sau_outfl) ? '0 : wd + 1'b1;
`endif
               if (tx_done && rx_done) begin
                  state    <= DONE;
                  sau_en_q <= 1'b0;
                  rx_valid <= 1'b1;
               end
`ifdef SAU_CTRL_TIMEOUT_EN
               else if (wd == 10'(TIMEOUT_CYC)) begin
                  state    <= ERR;
                  sau_en_q <= 1'b0;
                  err_q    <= 1'b1;
               end
`endif
            end
            DONE: begin
               if (rx_ready) begin
                  state    <= IDLE;
                  rx_valid <= 1'b0;
                  tx_ready <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               tx_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
